// File: rtl/cover_collector_pkg.sv
// Shared definitions for the toggle-coverage collector: default geometry
// and the collector state encoding.
package cover_collector_pkg;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_NUM_GROUPS = 8;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/cover_collector_fifo.sv
// Synchronous index FIFO with full/empty flags. A push is taken only when
// the FIFO is not full at the start of the cycle, so a push into a full
// FIFO is refused even if a pop happens in the same cycle.
module cover_collector_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Pointer update; reset and flush both empty the FIFO.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: accepts per-group hit vectors, records them in
// a covered bitmap and emits the global index of every newly covered point
// exactly once through an index FIFO.
module cover_toggle_collector
    import cover_collector_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int NUM_GROUPS = DEFAULT_NUM_GROUPS,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    clear,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [$clog2(NUM_GROUPS)-1:0]           in_group,
    input  logic [WIDTH-1:0]                        in_bits,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [$clog2(WIDTH*NUM_GROUPS)-1:0]     out_index,
    output logic [$clog2(WIDTH*NUM_GROUPS+1)-1:0]   covered_count
);

    localparam int N   = WIDTH * NUM_GROUPS;
    localparam int GW  = $clog2(NUM_GROUPS);
    localparam int IW  = $clog2(N);
    localparam int CW  = $clog2(N + 1);
    localparam int LBW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t                         r_state;
    logic                           r_in_ready;
    logic [WIDTH-1:0]               r_pending;
    logic [GW-1:0]                  r_group;
    logic [NUM_GROUPS-1:0][WIDTH-1:0] r_bitmap;
    logic [CW-1:0]                  r_count;

    logic                           w_accept;
    logic [WIDTH-1:0]               w_new;
    logic [WIDTH-1:0]               w_pending_next;
    logic [LBW-1:0]                 w_low_bit;
    logic                           w_found;
    logic [IW-1:0]                  w_push_index;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_fifo_full;
    logic                           w_fifo_empty;

    assign w_accept       = in_valid && r_in_ready;
    assign w_new          = in_bits & ~r_bitmap[in_group];
    // x & (x-1) drops the lowest set bit, i.e. the one pushed this cycle.
    assign w_pending_next = r_pending & (r_pending - 1'b1);
    assign w_push         = (r_state == DRAIN) && !w_fifo_full;
    assign w_pop          = !w_fifo_empty && out_ready;
    assign w_push_index   = IW'(r_group) * IW'(WIDTH) + IW'(w_low_bit);

    assign in_ready      = r_in_ready;
    assign out_valid     = !w_fifo_empty;
    assign covered_count = r_count;

    // Priority encoder: position of the lowest pending bit.
    always_comb begin
        w_low_bit = '0;
        w_found   = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_pending[i] && !w_found) begin
                w_low_bit = LBW'(i);
                w_found   = 1'b1;
            end
        end
    end

    // Collector FSM with bitmap, pending vector and covered count.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_pending  <= '0;
            r_group    <= '0;
            r_bitmap   <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_bitmap[in_group] <= r_bitmap[in_group] | in_bits;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept && (w_new != '0)) begin
                        r_pending  <= w_new;
                        r_group    <= in_group;
                        r_state    <= DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_push) begin
                        r_pending <= w_pending_next;
                        r_count   <= r_count + CW'(1);
                        if (w_pending_next == '0) begin
                            r_state    <= IDLE;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    cover_collector_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (IW)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_flush (clear),
        .i_push  (w_push),
        .i_data  (w_push_index),
        .i_pop   (w_pop),
        .o_data  (out_index),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector: a table of hit vectors with
// hand-computed newly-covered masks, plus hand-written multi-cycle sequences
// for latency, backpressure, clear, reset and full coverage.
module tb_cover_toggle_collector;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_group;
    logic [15:0] in_bits;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_index;
    logic [7:0]  covered_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] q_seen [$];
    int         q_exp  [$];

    typedef struct {
        logic [2:0]  grp;
        logic [15:0] bits;
        logic [15:0] exp_new;
        int          exp_count;
    } vec_t;

    vec_t tbl [7];

    cover_toggle_collector #(
        .WIDTH      (16),
        .NUM_GROUPS (8),
        .FIFO_DEPTH (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_group      (in_group),
        .in_bits       (in_bits),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .covered_count (covered_count)
    );

    always #5 clock = ~clock;

    // Record every index the consumer takes (sampled mid-cycle).
    always @(negedge clock) begin
        if (out_valid && out_ready && reset && !clear) begin
            q_seen.push_back(out_index);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] g, input logic [15:0] b);
        int n = 0;
        @(negedge clock);
        while (!in_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            chk("send_in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_valid = 1'b1;
            in_group = g;
            in_bits  = b;
            @(posedge clock);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        @(negedge clock);
        while (!(in_ready && !out_valid) && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        chk("idle_reached", 32'(in_ready && !out_valid), 32'd1);
    endtask

    task automatic cmp_queue(input string name);
        chk({name, "_n"}, 32'(q_seen.size()), 32'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < q_seen.size(); i++) begin
            chk({name, "_idx"}, 32'(q_seen[i]), 32'(q_exp[i]));
        end
    endtask

    initial begin
        tbl[0] = '{3'd2, 16'h0005, 16'h0000, 2};
        tbl[1] = '{3'd2, 16'h0007, 16'h0002, 3};
        tbl[2] = '{3'd5, 16'h8001, 16'h8001, 5};
        tbl[3] = '{3'd7, 16'h8000, 16'h8000, 6};
        tbl[4] = '{3'd0, 16'h0001, 16'h0001, 7};
        tbl[5] = '{3'd5, 16'hFFFF, 16'h7FFE, 21};
        tbl[6] = '{3'd7, 16'hC000, 16'h4000, 22};

        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_group  = '0;
        in_bits   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(covered_count), 32'd0);

        // Single hit: latency and ordering of 32, 34.
        q_seen.delete();
        send(3'd2, 16'h0005);
        chk("single_acc_in_ready", 32'(in_ready), 32'd0);
        chk("single_acc_out_valid", 32'(out_valid), 32'd0);
        @(posedge clock); #1;
        chk("single_first_valid", 32'(out_valid), 32'd1);
        chk("single_first_index", 32'(out_index), 32'd32);
        chk("single_first_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        chk("single_second_index", 32'(out_index), 32'd34);
        chk("single_in_ready_back", 32'(in_ready), 32'd1);
        wait_idle(20);
        q_exp = '{32, 34};
        cmp_queue("single");
        chk("single_count", 32'(covered_count), 32'd2);

        // Table-driven vectors, cumulative on the state left above.
        for (int v = 0; v < 7; v++) begin
            q_seen.delete();
            q_exp.delete();
            for (int b = 0; b < 16; b++) begin
                if (tbl[v].exp_new[b]) q_exp.push_back(int'(tbl[v].grp) * 16 + b);
            end
            send(tbl[v].grp, tbl[v].bits);
            repeat (3) @(negedge clock);
            wait_idle(50);
            cmp_queue($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_count", v), 32'(covered_count), 32'(tbl[v].exp_count));
            chk($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'd1);
        end

        // Clear, then backpressure on a fresh bitmap.
        @(posedge clock); #1 clear = 1'b1;
        @(posedge clock); #1 clear = 1'b0;
        chk("clear_count", 32'(covered_count), 32'd0);
        out_ready = 1'b0;
        q_seen.delete();
        send(3'd0, 16'hFFFF);
        repeat (12) @(posedge clock);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_index_stable", 32'(out_index), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_count", 32'(covered_count), 32'd8);
        end
        @(posedge clock); #1 out_ready = 1'b1;
        wait_idle(100);
        q_exp.delete();
        for (int i = 0; i < 16; i++) q_exp.push_back(i);
        cmp_queue("bp");
        chk("bp_final_count", 32'(covered_count), 32'd16);

        // Clear after the first push of a DRAIN.
        @(posedge clock); #1 out_ready = 1'b0;
        send(3'd1, 16'h00F0);
        @(posedge clock); #1;
        chk("clr_first_valid", 32'(out_valid), 32'd1);
        chk("clr_first_index", 32'(out_index), 32'd20);
        clear = 1'b1;
        @(posedge clock); #1 clear = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("clr_no_valid", 32'(out_valid), 32'd0);
            chk("clr_count", 32'(covered_count), 32'd0);
            chk("clr_in_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clock); #1 out_ready = 1'b1;
        q_seen.delete();
        send(3'd1, 16'h00F0);
        wait_idle(50);
        q_exp = '{20, 21, 22, 23};
        cmp_queue("clr_resend");
        chk("clr_resend_count", 32'(covered_count), 32'd4);

        // Reset for one edge during DRAIN.
        @(posedge clock); #1 out_ready = 1'b0;
        send(3'd3, 16'hFFFF);
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_count", 32'(covered_count), 32'd0);
        out_ready = 1'b1;

        // Full coverage of all 128 points.
        q_seen.delete();
        for (int g = 0; g < 8; g++) send(3'(g), 16'hFFFF);
        wait_idle(600);
        q_exp.delete();
        for (int i = 0; i < 128; i++) q_exp.push_back(i);
        cmp_queue("full");
        chk("full_count", 32'(covered_count), 32'd128);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
